// File: rtl/rect_motion_ctl_pkg.sv
// rect_motion_ctl_pkg: shared geometry, motion constants and state encoding for the rectangle path
package rect_motion_ctl_pkg;
  localparam int SCREEN_W   = 1024;
  localparam int FLOOR_Y    = 600;
  localparam int RECT_W     = 64;
  localparam int RECT_H     = 64;
  localparam int GRAVITY    = 1;
  localparam int VMAX       = 32;
  localparam int MIN_BOUNCE = 4;
  localparam logic [11:0] X_MAX = 12'(SCREEN_W - RECT_W);
  localparam logic [11:0] Y_MAX = 12'(FLOOR_Y - RECT_H);
  typedef enum logic [1:0] {IDLE = 2'd0, FALL = 2'd1, RISE = 2'd2, REST = 2'd3} state_t;
endpackage

// File: rtl/rect_motion_ctl_vblnk_tick.sv
// vblnk_tick: one-pclk pulse on the rising edge of vblnk (ports: pclk, rst, vblnk in; tick out)
module vblnk_tick (
  input  logic pclk,
  input  logic rst,
  input  logic vblnk,
  output logic tick
);
  logic vblnk_q;
  always_ff @(posedge pclk) vblnk_q <= rst ? 1'b0 : vblnk;
  assign tick = vblnk & ~vblnk_q;
endmodule

// File: rtl/rect_motion_ctl.sv
// rect_motion_ctl: frame-tick sequencer that follows the mouse, then drops/bounces the rectangle (ports: pclk, rst, vblnk, mouse_xpos/ypos/left in; xpos, ypos, state, busy out)
module rect_motion_ctl
  import rect_motion_ctl_pkg::*;
(
  input  logic        pclk,
  input  logic        rst,
  input  logic        vblnk,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic        mouse_left,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic [1:0]  state,
  output logic        busy
);
  state_t st, st_nx;
  logic tick, left_q, press_pend, pend, hit, stop, ceil, last;
  logic [5:0] vel, vel_nx, vn, vb;
  logic [6:0] vinc;
  logic [11:0] xpos_nx, ypos_nx, cx, cy, vel12;
  logic [12:0] yn;
  vblnk_tick u_tick (.pclk(pclk), .rst(rst), .vblnk(vblnk), .tick(tick));
  // a rising edge in the tick cycle itself counts as pending for that tick
  assign pend = press_pend | (mouse_left & ~left_q);
  always_ff @(posedge pclk) begin
    left_q     <= rst ? 1'b0 : mouse_left;
    press_pend <= rst ? 1'b0 : (tick ? 1'b0 : pend);
  end
  always_comb begin
    cx    = mouse_xpos > X_MAX ? X_MAX : mouse_xpos;
    cy    = mouse_ypos > Y_MAX ? Y_MAX : mouse_ypos;
    vinc  = {1'b0, vel} + 7'(GRAVITY);
    vn    = vinc > 7'(VMAX) ? 6'(VMAX) : vinc[5:0];
    yn    = {1'b0, ypos} + {7'd0, vn};
    hit   = yn >= {1'b0, Y_MAX};
    vb    = vn - (vn >> 2);
    stop  = vb < 6'(MIN_BOUNCE);
    vel12 = {6'd0, vel};
    ceil  = vel12 > ypos;
    last  = vel <= 6'(GRAVITY);
  end
  always_ff @(posedge pclk) st <= rst ? IDLE : st_nx;
  always_comb begin
    st_nx = st;
    if (tick)
      case (st)
        IDLE: st_nx = pend ? FALL : IDLE;
        FALL: st_nx = hit ? (stop ? REST : RISE) : FALL;
        RISE: st_nx = (ceil || last) ? FALL : RISE;
        REST: st_nx = pend ? IDLE : REST;
      endcase
  end
  always_comb begin
    xpos_nx = xpos;
    ypos_nx = ypos;
    vel_nx  = vel;
    if (tick)
      case (st)
        IDLE: begin
          xpos_nx = cx;
          ypos_nx = cy;
          vel_nx  = 6'd0;
        end
        FALL: begin
          ypos_nx = hit ? Y_MAX : yn[11:0];
          vel_nx  = hit ? (stop ? 6'd0 : vb) : vn;
        end
        RISE: begin
          ypos_nx = ceil ? 12'd0 : ypos - vel12;
          vel_nx  = (ceil || last) ? 6'd0 : vel - 6'(GRAVITY);
        end
        REST: ;
      endcase
  end
  always_ff @(posedge pclk) begin
    xpos <= rst ? 12'd0 : xpos_nx;
    ypos <= rst ? 12'd0 : ypos_nx;
    vel  <= rst ? 6'd0 : vel_nx;
  end
  assign state = st;
  assign busy  = (st == FALL) || (st == RISE);
endmodule

// File: tb/tb_rect_motion_ctl.sv
// tb_rect_motion_ctl: directed and randomized checks of rect_motion_ctl against a per-frame behavioural model
module tb_rect_motion_ctl;
  logic pclk = 0, rst = 1, vblnk = 0, mouse_left = 0;
  logic [11:0] mouse_xpos = 0, mouse_ypos = 0, xpos, ypos;
  logic [1:0] state;
  logic busy;
  int total = 0, bad = 0;
  int m_x, m_y, m_st, m_v;
  bit m_pend;

  rect_motion_ctl dut (.pclk(pclk), .rst(rst), .vblnk(vblnk), .mouse_xpos(mouse_xpos),
    .mouse_ypos(mouse_ypos), .mouse_left(mouse_left), .xpos(xpos), .ypos(ypos),
    .state(state), .busy(busy));

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".x"}, int'(xpos), m_x);
    chk({tag, ".y"}, int'(ypos), m_y);
    chk({tag, ".st"}, int'(state), m_st);
    chk({tag, ".busy"}, int'(busy), int'(m_st == 1 || m_st == 2));
  endtask

  // one frame of the documented motion rules, on plain integers
  task automatic model_frame(input bit p);
    int vn, vb;
    if (m_st == 0) begin
      m_x = int'(mouse_xpos) < 960 ? int'(mouse_xpos) : 960;
      m_y = int'(mouse_ypos) < 536 ? int'(mouse_ypos) : 536;
      if (p) begin m_st = 1; m_v = 0; end
    end else if (m_st == 1) begin
      vn = m_v + 1 > 32 ? 32 : m_v + 1;
      if (m_y + vn < 536) begin m_y += vn; m_v = vn; end
      else begin
        m_y = 536;
        vb = vn - vn / 4;
        if (vb < 4) begin m_st = 3; m_v = 0; end else begin m_st = 2; m_v = vb; end
      end
    end else if (m_st == 2) begin
      if (m_v > m_y) begin m_y = 0; m_v = 0; m_st = 1; end
      else begin
        m_y -= m_v;
        if (m_v <= 1) begin m_v = 0; m_st = 1; end else m_v -= 1;
      end
    end else if (p) m_st = 0;
  endtask

  task automatic press();
    @(negedge pclk) mouse_left = 1;
    @(negedge pclk) mouse_left = 0;
    m_pend = 1;
  endtask

  // tick with optional press in the tick cycle; vblnk held for hold cycles
  task automatic frame(input bit with_press, input int hold);
    @(negedge pclk);
    vblnk = 1;
    if (with_press) mouse_left = 1;
    model_frame(m_pend | with_press);
    m_pend = 0;
    @(negedge pclk);
    mouse_left = 0;
    repeat (hold - 1) @(negedge pclk);
    vblnk = 0;
    @(negedge pclk);
  endtask

  task automatic do_reset();
    @(negedge pclk) rst = 1;
    repeat (2) @(negedge pclk);
    rst = 0;
    m_x = 0; m_y = 0; m_st = 0; m_v = 0; m_pend = 0;
  endtask

  task automatic mouse(input int x, input int y);
    mouse_xpos = 12'(x);
    mouse_ypos = 12'(y);
  endtask

  initial begin
    do_reset();
    chk_all("reset");
    chk("reset.x0", int'(xpos), 0);
    chk("reset.y0", int'(ypos), 0);
    frame(0, 1);
    chk("idle_tick.st", int'(state), 0);

    mouse(100, 200); frame(0, 1);
    chk("follow.x", int'(xpos), 100); chk("follow.y", int'(ypos), 200);
    mouse(1000, 700); frame(0, 1);
    chk("clamp.x", int'(xpos), 960); chk("clamp.y", int'(ypos), 536);

    mouse(100, 200); press(); frame(0, 1);
    chk("drop.st", int'(state), 1); chk("drop.y", int'(ypos), 200);
    frame(0, 1); chk("fall1.y", int'(ypos), 201);
    frame(0, 1); chk("fall2.y", int'(ypos), 203);
    frame(0, 1); chk("fall3.y", int'(ypos), 206);
    chk("fall.x", int'(xpos), 100); chk_all("fall");

    do_reset(); mouse(10, 485); frame(0, 1); press(); frame(0, 1);
    repeat (9) frame(0, 1);
    chk("pre_hit.y", int'(ypos), 530);
    frame(0, 1); chk("bounce.y", int'(ypos), 536); chk("bounce.st", int'(state), 2);
    frame(0, 1); chk("rise.y", int'(ypos), 528); chk_all("rise");

    do_reset(); mouse(20, 528); frame(0, 1); press(); frame(0, 1);
    repeat (4) frame(0, 1);
    chk("rest.st", int'(state), 3); chk("rest.y", int'(ypos), 536); chk("rest.busy", int'(busy), 0);
    mouse(300, 100); frame(1, 1);
    chk("wake.st", int'(state), 0); chk("wake.y", int'(ypos), 536);
    frame(0, 1); chk("wake.x", int'(xpos), 300); chk("wake.y2", int'(ypos), 100);

    press(); frame(0, 1); frame(0, 1);
    chk("mid.busy", int'(busy), 1);
    @(negedge pclk) rst = 1; mouse_left = 1;
    @(negedge pclk) mouse_left = 0;
    @(negedge pclk) rst = 0;
    m_x = 0; m_y = 0; m_st = 0; m_v = 0; m_pend = 0;
    chk("rst_mid.st", int'(state), 0); chk("rst_mid.y", int'(ypos), 0);
    frame(0, 1); chk("rst_press.st", int'(state), 0);
    mouse(50, 60); press();
    @(negedge pclk) vblnk = 1;
    model_frame(1); m_pend = 0;
    @(negedge pclk); chk_all("hold1");
    repeat (99) @(negedge pclk);
    chk_all("hold100");
    vblnk = 0;
    @(negedge pclk);

    do_reset();
    for (int i = 0; i < 400; i++) begin
      mouse($urandom_range(0, 1200), $urandom_range(0, 800));
      if ($urandom_range(0, 5) == 0) press();
      frame($urandom_range(0, 7) == 0, $urandom_range(1, 3));
      chk_all("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
